// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory loader: FSM states, stream magic, word geometry.
// The CSUM state exists only when LOADER_CSUM_EN is defined.
package loader_pkg;

  localparam logic [7:0] MAGIC      = 8'hA5;
  localparam int         WORD_BYTES = 4;
  localparam int         WORD_W     = 8 * WORD_BYTES;
  localparam int         IDX_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
`ifdef LOADER_CSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/im_loader_byte_packer.sv
// Packs four accepted bytes (first byte most significant) into one word.
// word_valid pulses for one cycle on the edge after the 4th byte; en gates all state.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        rx_byte,
  output logic [1:0]        cnt,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [WORD_W-9:0] sh;

  always_ff @(posedge clk) begin
    if (clr) begin
      sh         <= '0;
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (en) begin
        if (cnt == 2'd3) begin
          word       <= {sh, rx_byte};
          word_valid <= 1'b1;
        end else begin
          sh <= {sh[WORD_W-17:0], rx_byte};
        end
        cnt <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/im_loader.sv
// Streams a magic/length/words(/checksum) byte stream into instruction memory, holding the CPU until done.
// One write per 4 data bytes on the following edge; rx_valid low stalls; LOADER_CSUM_EN adds a trailing XOR checksum.
module im_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              im_we,
  output logic [31:0]       im_addr,
  output logic [WORD_W-1:0] im_din,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_t           state;
  logic [7:0]       len_hi;
  logic [IDX_W-1:0] n;
  logic [IDX_W-1:0] idx;
  logic [1:0]       cnt;
  logic             take;
  logic [IDX_W-1:0] len;
`ifdef LOADER_CSUM_EN
  logic [7:0]       csum;
`endif

  assign take = rx_valid && rx_ready;
  assign len  = {len_hi, rx_byte};

  byte_packer u_packer (
    .clk        (clk),
    .clr        (clr),
    .en         (take && (state == DATA)),
    .rx_byte    (rx_byte),
    .cnt        (cnt),
    .word       (im_din),
    .word_valid (im_we)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      len_hi   <= '0;
      n        <= '0;
      idx      <= '0;
      im_addr  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
      rx_ready <= 1'b1;
`ifdef LOADER_CSUM_EN
      csum     <= '0;
`endif
    end else if (take) begin
      case (state)
        IDLE: begin
          if (rx_byte == MAGIC) state <= LEN_HI;
        end
        LEN_HI: begin
          len_hi <= rx_byte;
          state  <= LEN_LO;
        end
        LEN_LO: begin
          n <= len;
          if (32'(len) > MAX_WORDS) begin
            state    <= ERR;
            err      <= 1'b1;
            rx_ready <= 1'b0;
          end else if (len == '0) begin
`ifdef LOADER_CSUM_EN
            state    <= CSUM;
`else
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            rx_ready <= 1'b0;
`endif
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
`ifdef LOADER_CSUM_EN
          csum <= csum ^ rx_byte;
`endif
          // Address is registered alongside the packer's word so both land on the same edge.
          if (cnt == 2'd3) begin
            im_addr <= BASE_ADDR + {14'b0, idx, 2'b00};
            idx     <= idx + 1'b1;
            if (idx == n - 1'b1) begin
`ifdef LOADER_CSUM_EN
              state    <= CSUM;
`else
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              rx_ready <= 1'b0;
`endif
            end
          end
        end
`ifdef LOADER_CSUM_EN
        CSUM: begin
          rx_ready <= 1'b0;
          if (rx_byte == csum) begin
            state    <= DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state <= ERR;
            err   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader; streams follow the LOADER_CSUM_EN setting of the build.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_ready, im_we, cpu_hold, done, err;
  logic [31:0] im_addr, im_din;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  stim[$];
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  im_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut (
    .clk      (clk),
    .clr      (clr),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ready (rx_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_din   (im_din),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_we) begin
      wa.push_back(im_addr);
      wd.push_back(im_din);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wa.delete();
    wd.delete();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_we"},   {31'b0, im_we},    32'd0);
    check({tag, "_addr"}, im_addr,           32'd0);
    check({tag, "_din"},  im_din,            32'd0);
    check({tag, "_done"}, {31'b0, done},     32'd0);
    check({tag, "_err"},  {31'b0, err},      32'd0);
    check({tag, "_hold"}, {31'b0, cpu_hold}, 32'd1);
    check({tag, "_rdy"},  {31'b0, rx_ready}, 32'd1);
  endtask

  // Drives stim byte by byte starting on a falling edge, with gap idle cycles between bytes.
  task automatic play(input int gap);
    foreach (stim[i]) begin
      rx_valid = 1'b1;
      rx_byte  = stim[i];
      @(negedge clk);
      rx_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        rx_byte = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_a();
    stim = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h10, 8'h00, 8'h0A};
`ifdef LOADER_CSUM_EN
    stim.push_back(8'h17);
`endif
  endtask

  task automatic check_writes_a(input string tag);
    check({tag, "_wcount"}, wa.size(), 32'd2);
    if (wa.size() >= 2) begin
      check({tag, "_a0"}, wa[0], 32'h0000_0000);
      check({tag, "_d0"}, wd[0], 32'h2008_0005);
      check({tag, "_a1"}, wa[1], 32'h0000_0004);
      check({tag, "_d1"}, wd[1], 32'h2010_000A);
    end
    check({tag, "_done"}, {31'b0, done},     32'd1);
    check({tag, "_err"},  {31'b0, err},      32'd0);
    check({tag, "_hold"}, {31'b0, cpu_hold}, 32'd0);
    check({tag, "_rdy"},  {31'b0, rx_ready}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    clr = 1'b0;
    check_reset("rst");

    // Basic load, back-to-back bytes.
    load_a();
    play(0);
    check_writes_a("load");

    // Terminal: further bytes are refused and change nothing.
    stim = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    play(0);
    check("term_wcount", wa.size(), 32'd2);
    check("term_done", {31'b0, done}, 32'd1);

    // Leading garbage in IDLE is discarded.
    do_clr();
    check_reset("clr1");
    load_a();
    stim.push_front(8'h3C);
    stim.push_front(8'hFF);
    stim.push_front(8'h00);
    play(0);
    check_writes_a("garb");

    // Stalls with random bytes on the bus while rx_valid is low.
    do_clr();
    load_a();
    play(2);
    check_writes_a("stall");

    // Empty load.
    do_clr();
    stim = '{8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CSUM_EN
    stim.push_back(8'h00);
`endif
    play(1);
    check("empty_wcount", wa.size(), 32'd0);
    check("empty_done", {31'b0, done}, 32'd1);
    check("empty_hold", {31'b0, cpu_hold}, 32'd0);

    // Oversize count: 257 > 256.
    do_clr();
    stim = '{8'hA5, 8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    play(0);
    check("over_err", {31'b0, err}, 32'd1);
    check("over_done", {31'b0, done}, 32'd0);
    check("over_hold", {31'b0, cpu_hold}, 32'd1);
    check("over_rdy", {31'b0, rx_ready}, 32'd0);
    check("over_wcount", wa.size(), 32'd0);

    // Exactly MAX_WORDS is accepted and enters the data phase.
    do_clr();
    stim = '{8'hA5, 8'h01, 8'h00};
    play(0);
    check("max_err", {31'b0, err}, 32'd0);
    check("max_rdy", {31'b0, rx_ready}, 32'd1);
    check("max_hold", {31'b0, cpu_hold}, 32'd1);

`ifdef LOADER_CSUM_EN
    // Bad checksum.
    do_clr();
    load_a();
    void'(stim.pop_back());
    stim.push_back(8'h18);
    play(0);
    check("csum_err", {31'b0, err}, 32'd1);
    check("csum_done", {31'b0, done}, 32'd0);
    check("csum_hold", {31'b0, cpu_hold}, 32'd1);
`endif

    // Reset mid-word, then a clean restream.
    do_clr();
    stim = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08};
    play(0);
    do_clr();
    check_reset("mid");
    load_a();
    play(1);
    check_writes_a("reload");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
